mips_cpu_mem_access_ctrl: RTL and testbench

Sequences a single data-memory load or store for the multicycle MIPS CPU over an Avalon-style word bus. It latches the 2 LSBs of the ALU-computed address as the byte offset, drives a word-aligned bus request with byte enables, and handles wait states. It returns sign- or zero-extended load data, or flags a misaligned access without touching the bus. It sits between the ALU-out/rt registers and the data-memory port, and is started by the main control FSM.

---
 rtl/mips_cpu_mem_pkg.sv | 43 ++++
 rtl/mips_cpu_load_aligner.sv | 39 +++
 rtl/mips_cpu_mem_access_ctrl.sv | 140 ++++++++++++++
 tb/tb_mips_cpu_mem_access_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_mem_pkg.sv
// mips_cpu_mem_pkg
// Shared types and helpers for the data-memory access path of the multicycle
// MIPS CPU: the memory-operation encoding, the access-controller state type,
// and the store / alignment classification used by the controller.
package mips_cpu_mem_pkg;

    // Memory operation requested by the main control FSM.
    typedef enum logic [2:0] {
        LB  = 3'd0,
        LBU = 3'd1,
        LH  = 3'd2,
        LHU = 3'd3,
        LW  = 3'd4,
        SB  = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } mem_op_t;

    // Access-controller sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    function automatic logic is_store(input mem_op_t op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    // Halfwords need an even byte offset and words need offset zero; bytes
    // are never misaligned.
    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (op)
            LH, LHU, SH: mis = off[0];
            LW, SW:      mis = (off != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mips_cpu_load_aligner.sv
// mips_cpu_load_aligner
// Combinational load-data extraction: picks the byte or halfword lane
// selected by the byte offset out of the bus word and sign- or zero-extends
// it to 32 bits according to the load operation.
//
// Ports:
//   op          in   mem_op_t  load operation (LB, LBU, LH, LHU, LW)
//   off         in   2         byte offset within the word (addr[1:0])
//   readdata    in   32        raw little-endian bus word
//   load_value  out  32        extended load result
module mips_cpu_load_aligner
    import mips_cpu_mem_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  off,
    input  logic [31:0] readdata,
    output logic [31:0] load_value
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane i of the little-endian word lives in bits 8i+7:8i; a halfword is
    // always either the low or the high pair of lanes, so off[1] picks it.
    always_comb begin
        byte_lane = readdata[8*off +: 8];
        half_lane = off[1] ? readdata[31:16] : readdata[15:0];

        load_value = readdata;
        case (op)
            LB:      load_value = {{24{byte_lane[7]}}, byte_lane};
            LBU:     load_value = {24'd0, byte_lane};
            LH:      load_value = {{16{half_lane[15]}}, half_lane};
            LHU:     load_value = {16'd0, half_lane};
            default: load_value = readdata;
        endcase
    end

endmodule

// File: rtl/mips_cpu_mem_access_ctrl.sv
// mips_cpu_mem_access_ctrl
// Sequences one data-memory load or store for the multicycle MIPS CPU over an
// Avalon-style word bus. On an accepted start it latches the operation, the
// ALU address and the rt value, then either completes immediately with an
// address error (misaligned access, no bus cycle) or issues a single
// word-aligned bus request with byte enables, waiting out waitrequest.
//
// Ports:
//   clk, reset        system clock; synchronous active-high reset
//   start, op         one-cycle request and its mem_op_t (sampled in IDLE only)
//   addr, wdata       ALU byte address and store source (rt)
//   busy, done, err   not-idle flag, completion pulse, misaligned flag
//   rdata             extended load result, held until the next done
//   address, read, write, byteenable, writedata   bus request side
//   readdata, waitrequest                         bus response side
module mips_cpu_mem_access_ctrl
    import mips_cpu_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        waitrequest
);

    mem_state_t  state_q, state_d;
    mem_op_t     op_in;
    mem_op_t     op_q;
    logic [1:0]  off_q;
    logic [29:0] word_addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] load_value;
    logic [3:0]  lane_mask;
    logic        accept;

    assign op_in  = mem_op_t'(op);
    assign accept = (state_q == IDLE) && start;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a misaligned request skips the bus entirely and
    // completes straight from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = is_misaligned(op_in, addr[1:0]) ? DONE : REQ;
                end
            end
            REQ: begin
                if (!waitrequest) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latches and the load result. Everything the bus sees is taken
    // from these registers, so addr/wdata may change freely once accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= LB;
            off_q       <= 2'b00;
            word_addr_q <= 30'd0;
            wdata_q     <= 32'd0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            if (accept) begin
                op_q        <= op_in;
                off_q       <= addr[1:0];
                word_addr_q <= addr[31:2];
                wdata_q     <= wdata;
                err_q       <= is_misaligned(op_in, addr[1:0]);
            end
            if ((state_q == REQ) && !waitrequest && !is_store(op_q)) begin
                rdata_q <= load_value;
            end
        end
    end

    mips_cpu_load_aligner u_load_aligner (
        .op         (op_q),
        .off        (off_q),
        .readdata   (readdata),
        .load_value (load_value)
    );

    // Byte-lane mask and lane-replicated store data. Replication puts the
    // byte/half in every lane it could occupy, so only byteenable depends
    // on the offset.
    always_comb begin
        lane_mask = 4'b1111;
        writedata = wdata_q;
        case (op_q)
            LB, LBU, SB: lane_mask = 4'b0001 << off_q;
            LH, LHU, SH: lane_mask = off_q[1] ? 4'b1100 : 4'b0011;
            default:     lane_mask = 4'b1111;
        endcase
        case (op_q)
            SB:      writedata = {4{wdata_q[7:0]}};
            SH:      writedata = {2{wdata_q[15:0]}};
            default: writedata = wdata_q;
        endcase
    end

    assign address    = {word_addr_q, 2'b00};
    assign byteenable = (state_q == REQ) ? lane_mask : 4'b0000;
    assign read       = (state_q == REQ) && !is_store(op_q);
    assign write      = (state_q == REQ) && is_store(op_q);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign err        = (state_q == DONE) && err_q;
    assign rdata      = rdata_q;

endmodule

// File: tb/tb_mips_cpu_mem_access_ctrl.sv
// tb_mips_cpu_mem_access_ctrl
// Self-checking bench for the data-memory access controller. Expected bus
// signals and load results come from a behavioural model built from access
// size, offset arithmetic and word masks; directed cases are followed by a
// randomized sweep of operations, addresses and wait-state counts.
module tb_mips_cpu_mem_access_ctrl;
    import mips_cpu_mem_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int done_cycle = 0;
    logic [31:0] model_rdata;

    mips_cpu_mem_access_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .addr        (addr),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .rdata       (rdata),
        .address     (address),
        .read        (read),
        .write       (write),
        .byteenable  (byteenable),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Reference model: access size in bytes.
    function automatic int unsigned op_bytes(input mem_op_t o);
        case (o)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            default:     return 4;
        endcase
    endfunction

    function automatic bit model_store(input mem_op_t o);
        return (o == SB) || (o == SH) || (o == SW);
    endfunction

    function automatic bit model_misaligned(input mem_op_t o, input logic [1:0] off);
        return (int'(off) % op_bytes(o)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input mem_op_t o, input logic [1:0] off);
        int unsigned m;
        m = ((32'd1 << op_bytes(o)) - 1) << off;
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input mem_op_t o, input logic [31:0] w);
        case (o)
            SB:      return (w & 32'hFF) * 32'h0101_0101;
            SH:      return (w & 32'hFFFF) * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input mem_op_t o, input logic [1:0] off,
                                               input logic [31:0] word);
        logic [31:0] s;
        logic [31:0] b;
        logic [31:0] h;
        s = word >> (8 * off);
        b = s & 32'hFF;
        h = s & 32'hFFFF;
        case (o)
            LB:      return (b >= 32'd128)   ? b - 32'd256   : b;
            LBU:     return b;
            LH:      return (h >= 32'd32768) ? h - 32'd65536 : h;
            LHU:     return h;
            default: return word;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one transaction: k wait states; poke pulses start while busy.
    task automatic applyStimulus(input mem_op_t t_op, input logic [31:0] t_addr,
                                 input logic [31:0] t_wdata, input logic [31:0] t_word,
                                 input int k, input bit poke);
        logic [1:0] off;
        bit mis;
        bit st;
        off = t_addr[1:0];
        mis = model_misaligned(t_op, off);
        st  = model_store(t_op);

        @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_done", 32'(done), 32'd0);
        start       = 1'b1;
        op          = 3'(t_op);
        addr        = t_addr;
        wdata       = t_wdata;
        readdata    = t_word;
        waitrequest = (k > 0);

        @(negedge clk);
        start = 1'b0;
        addr  = $urandom;
        wdata = $urandom;
        if (mis) begin
            checkOutput("mis_done", 32'(done), 32'd1);
            checkOutput("mis_err", 32'(err), 32'd1);
            checkOutput("mis_read", 32'(read), 32'd0);
            checkOutput("mis_write", 32'(write), 32'd0);
            checkOutput("mis_rdata", rdata, model_rdata);
            done_cycle = cycle;
        end else begin
            for (int i = 0; i <= k; i++) begin
                waitrequest = (i < k);
                checkOutput("req_read", 32'(read), 32'(!st));
                checkOutput("req_write", 32'(write), 32'(st));
                checkOutput("req_address", address, {t_addr[31:2], 2'b00});
                checkOutput("req_be", 32'(byteenable), 32'(model_be(t_op, off)));
                if (st) checkOutput("req_wdata", writedata, model_wdata(t_op, t_wdata));
                checkOutput("req_done", 32'(done), 32'd0);
                checkOutput("req_busy", 32'(busy), 32'd1);
                if (poke && i == 0) begin
                    start = 1'b1;
                    op    = 3'(SB);
                    addr  = $urandom;
                end
                @(negedge clk);
                start = 1'b0;
            end
            if (!st) model_rdata = model_load(t_op, off, t_word);
            checkOutput("done_pulse", 32'(done), 32'd1);
            checkOutput("done_err", 32'(err), 32'd0);
            checkOutput("done_read", 32'(read), 32'd0);
            checkOutput("done_write", 32'(write), 32'd0);
            checkOutput("done_rdata", rdata, model_rdata);
            done_cycle = cycle;
        end
    endtask

    initial begin
        int prev_done;
        reset       = 1'b1;
        start       = 1'b0;
        op          = 3'd0;
        addr        = 32'd0;
        wdata       = 32'd0;
        readdata    = 32'd0;
        waitrequest = 1'b0;
        model_rdata = 32'd0;
        $display("[TB] starting");

        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_read", 32'(read), 32'd0);
        checkOutput("rst_write", 32'(write), 32'd0);
        checkOutput("rst_be", 32'(byteenable), 32'd0);
        checkOutput("rst_address", address, 32'd0);
        checkOutput("rst_writedata", writedata, 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        reset = 1'b0;

        // Directed cases.
        applyStimulus(LB,  32'h0000_1003, 32'h0,         32'h80FF_1234, 0, 1'b0);
        checkOutput("lb_value", rdata, 32'hFFFF_FF80);
        applyStimulus(LHU, 32'h0000_2002, 32'h0,         32'hBEEF_0000, 2, 1'b0);
        checkOutput("lhu_value", rdata, 32'h0000_BEEF);
        applyStimulus(SB,  32'h0000_0001, 32'h0000_00AB, 32'h1234_5678, 0, 1'b0);
        checkOutput("sb_keeps_rdata", rdata, 32'h0000_BEEF);
        applyStimulus(SW,  32'h0000_0006, 32'h5555_AAAA, 32'h0,         0, 1'b0);

        // Reset while a load is stalled.
        @(negedge clk);
        start = 1'b1; op = 3'(LW); addr = 32'h0000_3000; waitrequest = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("pre_reset_read", 32'(read), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_rdata = 32'd0;
        checkOutput("mid_rst_read", 32'(read), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_done", 32'(done), 32'd0);
        checkOutput("mid_rst_be", 32'(byteenable), 32'd0);
        checkOutput("mid_rst_rdata", rdata, 32'd0);
        @(negedge clk);
        checkOutput("post_rst_done", 32'(done), 32'd0);
        waitrequest = 1'b0;
        applyStimulus(LW, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 0, 1'b0);

        // Start while busy is ignored, then two back-to-back loads.
        applyStimulus(LW, 32'h0000_4004, 32'h0, 32'h0102_0304, 2, 1'b1);
        applyStimulus(LW, 32'h0000_5008, 32'h0, 32'h1111_2222, 0, 1'b0);
        prev_done = done_cycle;
        applyStimulus(LW, 32'h0000_600C, 32'h0, 32'h3333_4444, 0, 1'b0);
        checkOutput("b2b_spacing", 32'(done_cycle - prev_done), 32'd3);

        // Randomized sweep.
        for (int n = 0; n < 40; n++) begin
            applyStimulus(mem_op_t'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                          int'($urandom_range(0, 3)), 1'b0);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
